// File: rtl/sram_seq.sv
// rtl/sram_seq.sv - timed single-byte access sequencer for the 8-bit async SRAM bridge
// Optional bus turnaround cycle on direction change: define SRAM_SEQ_TURNAROUND_EN.
module sram_seq #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              m_chipselect_n,
    output logic              m_byteenable_n,
    output logic              m_write_n,
    output logic              m_read_n,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TURN    = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_valid;
    logic              r_req_ready;
    logic              r_cs_n;
    logic              r_be_n;
    logic              r_write_n;
    logic              r_read_n;
`ifdef SRAM_SEQ_TURNAROUND_EN
    logic              r_last_write;
`endif

    logic              w_accept;
    logic              w_dir;
    logic [1:0]        w_next;

    assign w_accept = req_valid && r_req_ready;
    // Direction of the access about to be strobed: fresh request when leaving IDLE, latched otherwise.
    assign w_dir    = (r_state == S_IDLE) ? req_write : r_write;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef SRAM_SEQ_TURNAROUND_EN
                    w_next = (req_write != r_last_write) ? S_TURN : S_ACCESS;
`else
                    w_next = S_ACCESS;
`endif
                end
            end
            S_TURN:    w_next = S_ACCESS;
            S_ACCESS:  w_next = (r_cnt == 4'd0) ? S_RECOVER : S_ACCESS;
            S_RECOVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode, so strobes change only on clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_rsp_valid  <= 1'b0;
            r_req_ready  <= 1'b0;
            r_cs_n       <= 1'b1;
            r_be_n       <= 1'b1;
            r_write_n    <= 1'b1;
            r_read_n     <= 1'b1;
`ifdef SRAM_SEQ_TURNAROUND_EN
            r_last_write <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_RECOVER);
            r_cs_n      <= (w_next != S_ACCESS);
            r_be_n      <= (w_next != S_ACCESS);
            r_write_n   <= !((w_next == S_ACCESS) && w_dir);
            r_read_n    <= !((w_next == S_ACCESS) && !w_dir);
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= WAIT_INIT;
            end
            if (r_state == S_ACCESS) begin
                if (r_cnt == 4'd0) begin
                    if (!r_write) begin
                        r_rdata <= m_readdata;
                    end
`ifdef SRAM_SEQ_TURNAROUND_EN
                    r_last_write <= r_write;
`endif
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rdata;
    assign m_chipselect_n = r_cs_n;
    assign m_byteenable_n = r_be_n;
    assign m_write_n      = r_write_n;
    assign m_read_n       = r_read_n;
    assign m_address      = r_addr;
    assign m_writedata    = r_wdata;

endmodule

// File: doc/sram_seq.md
# sram_seq

Access sequencer placed directly upstream of the 8-bit asynchronous SRAM bridge. Accepts single-byte read/write requests on a valid/ready handshake and converts each into a timed, fully registered active-low strobe sequence (chip select, byte enable, read or write) with a programmable number of wait states. Captures read data at the end of the strobe window and returns a one-cycle response pulse. Serves as the single SRAM master behind the watch's CPU/display arbitration.

## Interface
- `ADDR_W`, 17: address width; matches the bridge address bus.
- `DATA_W`, 8: data width.
- `WAIT_CYCLES`, 2: extra strobe cycles per access, legal range 0..15.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle pulse; access complete.
- `rsp_rdata` out DATA_W: read data; held until the next read completes.
- `m_chipselect_n`, `m_byteenable_n`, `m_write_n`, `m_read_n` out 1 each: strobes to the bridge.
- `m_address` out ADDR_W, `m_writedata` out DATA_W: to the bridge.
- `m_readdata` in DATA_W: from the bridge.

## Operation
- Handshake: request accepted on a rising edge where `req_valid && req_ready`. `req_ready` = 1 only in IDLE. Address, data and direction are latched on acceptance; later changes on `req_*` are ignored.
- States: IDLE, TURN (only with the macro), ACCESS, RECOVER.
- IDLE: all strobes 1. On acceptance go to ACCESS, or TURN when turnaround applies; load wait counter with WAIT_CYCLES.
- TURN: one cycle, strobes 1, address/data already driven; then ACCESS.
- ACCESS: `m_chipselect_n`=0, `m_byteenable_n`=0, and `m_read_n`=0 (read) or `m_write_n`=0 (write); lasts WAIT_CYCLES+1 cycles. Counter decrements each cycle; at zero go to RECOVER, and for reads register `m_readdata` into `rsp_rdata` on that same edge.
- RECOVER: one cycle, all strobes 1, `m_address`/`m_writedata` held (address and data hold time). `rsp_valid`=1 for reads and writes. Then IDLE.
- `m_address` and `m_writedata` change only on acceptance; they keep the last value in IDLE.
- Counter width = 4 bits; WAIT_CYCLES=0 yields a single-cycle ACCESS.
- Reset (any state, including mid-ACCESS): immediately strobes 1, `req_ready` 0 while reset is asserted and 1 after, state IDLE, `rsp_valid` 0, `rsp_rdata` 0, `m_address` 0, `m_writedata` 0, last-op record = read. An interrupted access produces no response.

## Timing
- All outputs are registered; no combinational path from `req_*` or `m_readdata` to any output.
- Request accepted at edge 0: ACCESS occupies cycles 1..WAIT_CYCLES+1, RECOVER (with `rsp_valid`) is cycle WAIT_CYCLES+2, and `req_ready` returns to 1 in cycle WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles; add 1 cycle when TURN is inserted.
- `m_readdata` is sampled at the end of the last ACCESS cycle, while `m_read_n` is still 0.
- A request held valid through RECOVER is accepted on the first IDLE edge.

## Configuration
- `SRAM_SEQ_TURNAROUND_EN` defined: the sequencer records the direction of the last completed access. A request whose direction differs from the last completed access passes through TURN (1 idle cycle) before ACCESS, for bus turnaround.
- Not defined: TURN state and direction record are absent; every request goes IDLE -> ACCESS.

## Test plan
- Reset and idle: hold `reset_n`=0 -> all strobes 1, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0x00; release -> `req_ready`=1 on the next cycle.
- Write then read, WAIT_CYCLES=2: write 0x5A to 0x1F00A, then read 0x1F00A against an SRAM model -> `m_write_n` low exactly 3 cycles, `rsp_valid` in cycle 4 after acceptance; the read returns `rsp_rdata`=0x5A with `rsp_valid` in cycle 4 after acceptance.
- WAIT_CYCLES=0 back-to-back: 8 reads with `req_valid` held high -> one access every 3 cycles, 8 `rsp_valid` pulses, data matching the model.
- Turnaround (macro on): read, write, write -> one TURN cycle before the first write only, all strobes 1 during TURN; with the macro off, no TURN cycle.
- Reset mid-ACCESS: assert `reset_n`=0 in the second ACCESS cycle of a write -> `m_write_n` and `m_chipselect_n` go to 1 without waiting for a clock edge, and no `rsp_valid` follows.
- Input isolation: change `req_addr`/`req_wdata` during ACCESS -> `m_address`/`m_writedata` keep the latched values through RECOVER.
